// File: rtl/trace_pkg.sv
// trace_pkg: shared types for the CPU trace capture block.
//   state_t     - capture FSM states (IDLE, RUN, DONE)
//   trace_rec_t - one record {pc, inst, rw, flag} at the default sample widths
//   REC_W       - width of trace_rec_t
//   CNT_W       - width of the captured/overflow counters
//   sat_inc     - saturating increment for those counters
package trace_pkg;

  localparam int CNT_W      = 8;
  localparam int PC_W_DEF   = 32;
  localparam int INST_W_DEF = 32;
  localparam int RA_W_DEF   = 5;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Field order matches out_data: pc sits in the MSBs.
  typedef struct packed {
    logic [PC_W_DEF-1:0]   pc;
    logic [INST_W_DEF-1:0] inst;
    logic [RA_W_DEF-1:0]   rw;
    logic                  flag;
  } trace_rec_t;

  localparam int REC_W = $bits(trace_rec_t);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: register-based first-word-fall-through FIFO.
//   clk, rst   - clock, asynchronous active-low reset (empties the FIFO)
//   push       - write data_in this cycle (ignored unless push_ok)
//   pop        - consume the head this cycle (ignored when empty)
//   data_in    - record to write
//   push_ok    - a push this cycle would be accepted (not full, or full with a pop)
//   empty      - no records held
//   head       - oldest record; zero while empty
// Pointers carry one extra MSB so full and empty are distinguishable
// with a plain compare; wrap-around is the natural counter overflow.
module trace_fifo #(
  parameter int W     = 70,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] data_in,
  output logic         push_ok,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wptr, rptr;
  logic [W-1:0] mem [DEPTH];
  logic         full, do_pop, do_push;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop frees the slot in the same cycle, so a full FIFO can still take a push.
  assign push_ok = !full || do_pop;
  assign do_push = push && push_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= data_in;
  end

  assign head = empty ? '0 : mem[rptr[AW-1:0]];

endmodule

// File: rtl/cpu_trace_capture.sv
// cpu_trace_capture: samples the CPU top's per-cycle observation outputs
// into a record FIFO and streams them out on a valid/ready port.
//   clk, rst       - clock, asynchronous active-low reset
//   start, stop    - single-cycle pulses arming / ending a capture run
//   trace_valid    - pc_in/inst_in/rw_in/flag_in are meaningful this cycle
//   out_valid/out_ready/out_data - record stream, out_data = {pc, inst, rw, flag}
//   busy, done     - FSM is in RUN / DONE
//   captured_cnt   - records pushed this run (saturating)
//   overflow_cnt   - records dropped this run on a full FIFO (saturating)
// Optional build macro TRACE_PC_FILTER_EN: when defined, a sample is only a
// push candidate if its PC differs from the last pushed PC; repeats are
// silently skipped and counted nowhere.
module cpu_trace_capture
  import trace_pkg::*;
#(
  parameter int PC_W        = 32,
  parameter int INST_W      = 32,
  parameter int RA_W        = 5,
  parameter int DEPTH       = 8,
  parameter int NUM_CAPTURE = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        trace_valid,
  input  logic [PC_W-1:0]             pc_in,
  input  logic [INST_W-1:0]           inst_in,
  input  logic [RA_W-1:0]             rw_in,
  input  logic                        flag_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [PC_W+INST_W+RA_W:0]   out_data,
  output logic                        busy,
  output logic                        done,
  output logic [CNT_W-1:0]            captured_cnt,
  output logic [CNT_W-1:0]            overflow_cnt
);

  localparam int RW = PC_W + INST_W + RA_W + 1;

  state_t           state, state_nx;
  logic             empty, push_ok, pop;
  logic             enter_run, pc_new, cand, push, drop, hit_limit;
  logic [CNT_W-1:0] cap_nx;

  assign enter_run = start && (state != RUN);

`ifdef TRACE_PC_FILTER_EN
  logic [PC_W-1:0] last_pc;
  logic            last_vld;

  // Only PCs that actually made it into the FIFO are remembered; a dropped
  // sample does not suppress a retry of the same PC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_pc  <= '0;
      last_vld <= 1'b0;
    end else if (enter_run) begin
      last_pc  <= '0;
      last_vld <= 1'b0;
    end else if (push) begin
      last_pc  <= pc_in;
      last_vld <= 1'b1;
    end
  end

  assign pc_new = !last_vld || (pc_in != last_pc);
`else
  assign pc_new = 1'b1;
`endif

  assign pop  = out_valid && out_ready;
  assign cand = (state == RUN) && trace_valid && pc_new;
  assign push = cand && push_ok;
  assign drop = cand && !push_ok;

  // Limit test uses the post-push count so the run ends on the same edge
  // as the final push.
  assign cap_nx    = push ? sat_inc(captured_cnt) : captured_cnt;
  assign hit_limit = int'(cap_nx) >= NUM_CAPTURE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (stop || hit_limit) state_nx = DONE;
      DONE:    if (start) state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      captured_cnt <= '0;
      overflow_cnt <= '0;
    end else if (enter_run) begin
      captured_cnt <= '0;
      overflow_cnt <= '0;
    end else begin
      if (push) captured_cnt <= cap_nx;
      if (drop) overflow_cnt <= sat_inc(overflow_cnt);
    end
  end

  trace_fifo #(.W(RW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .data_in ({pc_in, inst_in, rw_in, flag_in}),
    .push_ok (push_ok),
    .empty   (empty),
    .head    (out_data)
  );

  assign out_valid = !empty;
  assign busy      = (state == RUN);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_cpu_trace_capture.sv
// Scoreboard bench for cpu_trace_capture: a queue-based reference model
// predicts each pushed record and the status outputs; a separate monitor
// compares every record the DUT hands out against the expected queue.
module tb_cpu_trace_capture;
  import trace_pkg::*;

  localparam int DEPTH = 8;
  localparam int NCAP  = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, stop = 1'b0, trace_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] pc_in = '0, inst_in = '0;
  logic [4:0]  rw_in = '0;
  logic        flag_in = 1'b0;
  logic        out_valid, busy, done;
  logic [69:0] out_data;
  logic [7:0]  captured_cnt, overflow_cnt;

  always #5 clk = ~clk;

  cpu_trace_capture #(.DEPTH(DEPTH), .NUM_CAPTURE(NCAP)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .trace_valid(trace_valid),
    .pc_in(pc_in), .inst_in(inst_in), .rw_in(rw_in), .flag_in(flag_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .captured_cnt(captured_cnt), .overflow_cnt(overflow_cnt)
  );

  // Reference model: 0 idle, 1 running, 2 done; occ = records held.
  int          mst, occ, mcap, movf;
  bit          lv;
  logic [31:0] lpc;
  trace_rec_t  exp_q[$];
  int          compared = 0, mismatched = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    mst = 0; occ = 0; mcap = 0; movf = 0; lv = 0; lpc = '0;
    exp_q.delete();
  endtask

  // Monitor: every accepted record must match the oldest predicted one.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL out_data: got %0h expected none", out_data);
      end else begin
        chk("out_data", out_data, exp_q.pop_front());
      end
    end
  end

  // One clock: drive inputs, predict, take the edge, check status outputs.
  // Entered and left at posedge+2.
  task automatic cycle(input bit s, input bit sp, input bit tv, input bit rdy,
                       input logic [31:0] pc, input logic [31:0] inst,
                       input logic [4:0] rw, input bit fl);
    bit pass, cand, mpop, ok, push, drop;
    start = s; stop = sp; trace_valid = tv; out_ready = rdy;
    pc_in = pc; inst_in = inst; rw_in = rw; flag_in = fl;
    @(negedge clk);
    pass = 1'b1;
`ifdef TRACE_PC_FILTER_EN
    pass = !lv || (pc != lpc);
`endif
    cand = (mst == 1) && tv && pass;
    mpop = (occ > 0) && rdy;
    ok   = (occ < DEPTH) || mpop;
    push = cand && ok;
    drop = cand && !ok;
    @(posedge clk);
    occ = occ - int'(mpop) + int'(push);
    if (push) begin
      exp_q.push_back('{pc: pc, inst: inst, rw: rw, flag: fl});
      if (mcap < 255) mcap++;
      lv = 1'b1; lpc = pc;
    end
    if (drop && movf < 255) movf++;
    if (mst != 1 && s) begin
      mst = 1; mcap = 0; movf = 0; lv = 1'b0;
    end else if (mst == 1 && (sp || mcap >= NCAP)) begin
      mst = 2;
    end
    #1;
    chk("busy", busy, mst == 1);
    chk("done", done, mst == 2);
    chk("captured_cnt", captured_cnt, mcap);
    chk("overflow_cnt", overflow_cnt, movf);
    chk("out_valid", out_valid, occ > 0);
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, rdy, '0, '0, '0, 0);
  endtask

  task automatic sample(input logic [31:0] pc, input logic [4:0] rw, input bit rdy);
    cycle(0, 0, 1, rdy, pc, 32'h0000_0013, rw, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    // Reset held with toggling inputs: everything must read zero.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2;
      start = i[0]; stop = i[1]; trace_valid = 1'b1; out_ready = ~i[0];
      pc_in = $urandom; inst_in = $urandom;
    end
    #1;
    chk("rst out_valid", out_valid, 0);
    chk("rst out_data", out_data, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst captured", captured_cnt, 0);
    chk("rst overflow", overflow_cnt, 0);
    @(posedge clk); #2;
    start = 0; stop = 0; trace_valid = 0; out_ready = 0;
    rst = 1'b1;
    idle(2, 0);
    chk("idle busy", busy, 0);

    // Basic stream.
    cycle(1, 0, 0, 1, '0, '0, '0, 0);
    for (int i = 0; i < 4; i++) sample(32'(i * 4), 5'(i + 1), 1);
    chk("basic captured", captured_cnt, 4);
    chk("basic busy", busy, 1);
    idle(3, 1);

    // Backpressure and overflow on a fresh run.
    cycle(0, 1, 0, 1, '0, '0, '0, 0);
    cycle(1, 0, 0, 0, '0, '0, '0, 0);
    for (int i = 0; i < 10; i++) sample(32'(i * 4), 5'(i), 0);
    chk("bp overflow", overflow_cnt, 2);
    chk("bp head pc", out_data[69:38], 0);
    chk("bp out_valid", out_valid, 1);
    idle(10, 1);
    chk("bp drained", out_valid, 0);

    // Auto-stop after NUM_CAPTURE pushes.
    cycle(0, 1, 0, 1, '0, '0, '0, 0);
    cycle(1, 0, 0, 1, '0, '0, '0, 0);
    for (int i = 0; i < 20; i++) sample(32'(i * 4 + 100), 5'(i), 1);
    chk("auto done", done, 1);
    chk("auto captured", captured_cnt, 16);
    idle(2, 1);
    cycle(1, 0, 0, 1, '0, '0, '0, 0);
    chk("restart captured", captured_cnt, 0);

    // Early stop after three pushes.
    for (int i = 0; i < 3; i++) sample(32'(i * 4 + 200), 5'(i), 1);
    cycle(0, 1, 0, 1, '0, '0, '0, 0);
    chk("stop done", done, 1);
    chk("stop captured", captured_cnt, 3);
    idle(2, 1);

    // Reset in the middle of a run with buffered records.
    cycle(1, 0, 0, 0, '0, '0, '0, 0);
    for (int i = 0; i < 5; i++) sample(32'(i * 4 + 300), 5'(i), 0);
    #1 rst = 1'b0;
    #1;
    chk("midrst out_valid", out_valid, 0);
    chk("midrst busy", busy, 0);
    model_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    idle(1, 1);

`ifdef TRACE_PC_FILTER_EN
    // Repeated PCs are skipped.
    cycle(1, 0, 0, 1, '0, '0, '0, 0);
    sample(0, 1, 1); sample(0, 2, 1); sample(0, 3, 1);
    sample(4, 4, 1); sample(4, 5, 1); sample(8, 6, 1);
    idle(2, 1);
    chk("filter captured", captured_cnt, 3);
    chk("filter overflow", overflow_cnt, 0);
    cycle(0, 1, 0, 1, '0, '0, '0, 0);
`endif

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      logic [31:0] pc;
`ifdef TRACE_PC_FILTER_EN
      pc = {28'd0, 2'($urandom_range(0, 3)), 2'b00};
`else
      pc = $urandom;
`endif
      cycle($urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0,
            ($urandom % 4) != 0, ($urandom % 3) != 0,
            pc, $urandom, 5'($urandom), 1'($urandom));
    end
    idle(12, 1);
    chk("scoreboard empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
